except_ctrl: RTL



---
 rtl/except_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/except_ctrl.sv
// except_ctrl: picks interrupt / synchronous exception / ERET for the MEM instruction, runs a fixed-length flush and merges stalls.
// Optional interrupt detection is compiled in when EXC_IRQ_EN is defined.
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        mem_valid_i,
    input  logic        exc_req_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [5:0]  stall_o,
    output logic        busy_o
);
    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [4:0] CODE_ERET = 5'd14;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] excepttype_q;
    logic [31:0] addr_q;
    logic        ds_q;
    logic        flush_q;
    logic [31:0] new_pc_q;

    logic        irq_pending;
    logic        code_ok;
    logic        take_irq;
    logic        take_exc;
    logic        unused_cp0;

`ifdef EXC_IRQ_EN
    assign irq_pending = cp0_status_i[0] & ~cp0_status_i[1]
                       & (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));
`else
    assign irq_pending = 1'b0;
`endif
    assign unused_cp0 = ^{cp0_status_i, cp0_cause_i};

    always_comb begin
        code_ok = 1'b0;
        case (exc_code_i)
            5'd8, 5'd10, 5'd12, 5'd13, 5'd14: code_ok = 1'b1;
            default:                          code_ok = 1'b0;
        endcase
    end

    // Interrupt has priority; both only considered while idle.
    assign take_irq = (state_q == IDLE) & mem_valid_i & irq_pending;
    assign take_exc = (state_q == IDLE) & mem_valid_i & exc_req_i & code_ok & ~take_irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            excepttype_q <= 32'd0;
            addr_q       <= 32'd0;
            ds_q         <= 1'b0;
            flush_q      <= 1'b0;
            new_pc_q     <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_irq || take_exc) begin
                        state_q      <= FLUSH;
                        cnt_q        <= CNT_INIT;
                        excepttype_q <= take_irq ? 32'd1 : {27'd0, exc_code_i};
                        addr_q       <= mem_pc_i;
                        ds_q         <= mem_in_delayslot_i;
                        flush_q      <= 1'b1;
                        new_pc_q     <= (take_exc && exc_code_i == CODE_ERET) ? cp0_epc_i : EXC_VECTOR;
                    end
                end
                FLUSH: begin
                    excepttype_q <= 32'd0;
                    if (cnt_q == 4'd0) begin
                        state_q  <= IDLE;
                        flush_q  <= 1'b0;
                        new_pc_q <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = 6'b000000;
        if (state_q == FLUSH)  stall_o = 6'b000000;
        else if (stallreq_ex)  stall_o = 6'b001111;
        else if (stallreq_id)  stall_o = 6'b000111;
    end

    assign excepttype_o        = excepttype_q;
    assign current_inst_addr_o = addr_q;
    assign is_in_delayslot_o   = ds_q;
    assign flush_o             = flush_q;
    assign new_pc_o            = new_pc_q;
    assign busy_o              = (state_q == FLUSH);
endmodule
